// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-lite arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_RESP = 2'd2
  } rd_state_t;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  function automatic int unsigned grant_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_rr_arbiter.sv
// Combinational round-robin arbiter; define AXIL_ARB_FIXED_PRIO_EN for
// fixed lowest-index-wins priority (pointer then ignored).
module axil_rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int unsigned S_COUNT = 2,
  parameter int unsigned GW      = grant_width(S_COUNT)
) (
  input  logic [S_COUNT-1:0] req_i,
  input  logic [GW-1:0]      ptr_i,
  output logic [GW-1:0]      grant_o,
  output logic               grant_valid_o
);

`ifdef AXIL_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    for (int unsigned k = 0; k < S_COUNT; k++) begin
      if (!grant_valid_o && req_i[k]) begin
        grant_valid_o = 1'b1;
        grant_o       = GW'(k);
      end
    end
  end
`else
  logic [2*S_COUNT-1:0] req_dbl;
  logic [S_COUNT-1:0]   req_rot;
  int unsigned          idx;

  assign req_dbl = {req_i, req_i};
  assign req_rot = S_COUNT'(req_dbl >> ptr_i);

  // Search upward from the pointer; req_rot[k] is port (ptr + k) mod S_COUNT.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    for (int unsigned k = 0; k < S_COUNT; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= S_COUNT) idx = idx - S_COUNT;
      if (!grant_valid_o && req_rot[k]) begin
        grant_valid_o = 1'b1;
        grant_o       = GW'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/axil_arbiter.sv
// Shares one AXI4-lite master among S_COUNT requesters, one outstanding
// write and one outstanding read. Macro: AXIL_ARB_FIXED_PRIO_EN.
module axil_arbiter
  import axil_arb_pkg::*;
#(
  parameter int unsigned S_COUNT    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]    s_axil_awaddr,
  input  logic [S_COUNT*3-1:0]             s_axil_awprot,
  input  logic [S_COUNT-1:0]               s_axil_awvalid,
  output logic [S_COUNT-1:0]               s_axil_awready,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axil_wdata,
  input  logic [S_COUNT*STRB_WIDTH-1:0]    s_axil_wstrb,
  input  logic [S_COUNT-1:0]               s_axil_wvalid,
  output logic [S_COUNT-1:0]               s_axil_wready,
  output logic [S_COUNT*2-1:0]             s_axil_bresp,
  output logic [S_COUNT-1:0]               s_axil_bvalid,
  input  logic [S_COUNT-1:0]               s_axil_bready,
  input  logic [S_COUNT*ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic [S_COUNT*3-1:0]             s_axil_arprot,
  input  logic [S_COUNT-1:0]               s_axil_arvalid,
  output logic [S_COUNT-1:0]               s_axil_arready,
  output logic [S_COUNT*DATA_WIDTH-1:0]    s_axil_rdata,
  output logic [S_COUNT*2-1:0]             s_axil_rresp,
  output logic [S_COUNT-1:0]               s_axil_rvalid,
  input  logic [S_COUNT-1:0]               s_axil_rready,
  output logic [ADDR_WIDTH-1:0]            m_axil_awaddr,
  output logic [2:0]                       m_axil_awprot,
  output logic                             m_axil_awvalid,
  input  logic                             m_axil_awready,
  output logic [DATA_WIDTH-1:0]            m_axil_wdata,
  output logic [STRB_WIDTH-1:0]            m_axil_wstrb,
  output logic                             m_axil_wvalid,
  input  logic                             m_axil_wready,
  input  logic [1:0]                       m_axil_bresp,
  input  logic                             m_axil_bvalid,
  output logic                             m_axil_bready,
  output logic [ADDR_WIDTH-1:0]            m_axil_araddr,
  output logic [2:0]                       m_axil_arprot,
  output logic                             m_axil_arvalid,
  input  logic                             m_axil_arready,
  input  logic [DATA_WIDTH-1:0]            m_axil_rdata,
  input  logic [1:0]                       m_axil_rresp,
  input  logic                             m_axil_rvalid,
  output logic                             m_axil_rready,
  output logic                             wr_busy,
  output logic                             rd_busy,
  output logic [grant_width(S_COUNT)-1:0]  wr_grant,
  output logic [grant_width(S_COUNT)-1:0]  rd_grant
);

  localparam int unsigned GW = grant_width(S_COUNT);

  wr_state_t       wr_state_q, wr_state_d;
  rd_state_t       rd_state_q, rd_state_d;
  logic [GW-1:0]   wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
  logic [GW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            aw_all, w_all;
  logic [GW-1:0]   wr_arb_grant, rd_arb_grant;
  logic            wr_arb_valid, rd_arb_valid;

  logic [ADDR_WIDTH-1:0] awaddr_a [S_COUNT];
  logic [2:0]            awprot_a [S_COUNT];
  logic [DATA_WIDTH-1:0] wdata_a  [S_COUNT];
  logic [STRB_WIDTH-1:0] wstrb_a  [S_COUNT];
  logic [ADDR_WIDTH-1:0] araddr_a [S_COUNT];
  logic [2:0]            arprot_a [S_COUNT];
  logic [1:0]            bresp_a  [S_COUNT];
  logic [DATA_WIDTH-1:0] rdata_a  [S_COUNT];
  logic [1:0]            rresp_a  [S_COUNT];

  // Per-port views of the flattened upstream buses.
  for (genvar i = 0; i < S_COUNT; i++) begin : g_port
    assign awaddr_a[i] = s_axil_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign awprot_a[i] = s_axil_awprot[i*3 +: 3];
    assign wdata_a[i]  = s_axil_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_a[i]  = s_axil_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
    assign araddr_a[i] = s_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign arprot_a[i] = s_axil_arprot[i*3 +: 3];
    assign s_axil_bresp[i*2 +: 2]                 = bresp_a[i];
    assign s_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdata_a[i];
    assign s_axil_rresp[i*2 +: 2]                 = rresp_a[i];
  end

  axil_rr_arbiter #(.S_COUNT(S_COUNT), .GW(GW)) u_wr_arb (
    .req_i         (s_axil_awvalid),
    .ptr_i         (wr_ptr_q),
    .grant_o       (wr_arb_grant),
    .grant_valid_o (wr_arb_valid)
  );

  axil_rr_arbiter #(.S_COUNT(S_COUNT), .GW(GW)) u_rd_arb (
    .req_i         (s_axil_arvalid),
    .ptr_i         (rd_ptr_q),
    .grant_o       (rd_arb_grant),
    .grant_valid_o (rd_arb_valid)
  );

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] g);
`ifdef AXIL_ARB_FIXED_PRIO_EN
    return GW'(0) & g;
`else
    int unsigned n;
    n = 32'(g) + 1;
    if (n >= S_COUNT) n = 0;
    return GW'(n);
`endif
  endfunction

  // Payloads follow the frozen grant; only valids/readies are gated by state.
  assign m_axil_awaddr = awaddr_a[wr_grant_q];
  assign m_axil_awprot = awprot_a[wr_grant_q];
  assign m_axil_wdata  = wdata_a[wr_grant_q];
  assign m_axil_wstrb  = wstrb_a[wr_grant_q];
  assign m_axil_araddr = araddr_a[rd_grant_q];
  assign m_axil_arprot = arprot_a[rd_grant_q];

  assign wr_busy  = (wr_state_q != WR_IDLE);
  assign rd_busy  = (rd_state_q != RD_IDLE);
  assign wr_grant = wr_grant_q;
  assign rd_grant = rd_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      wr_grant_q <= '0;
      rd_grant_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Write path: AW and W may complete in either order; B only in WR_RESP.
  always_comb begin
    wr_state_d     = wr_state_q;
    wr_grant_d     = wr_grant_q;
    wr_ptr_d       = wr_ptr_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    aw_all         = 1'b0;
    w_all          = 1'b0;
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    s_axil_awready = '0;
    s_axil_wready  = '0;
    s_axil_bvalid  = '0;
    for (int unsigned i = 0; i < S_COUNT; i++) bresp_a[i] = AXIL_RESP_OKAY;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_arb_valid) begin
          wr_grant_d = wr_arb_grant;
          wr_state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        m_axil_awvalid             = s_axil_awvalid[wr_grant_q] & ~aw_done_q;
        s_axil_awready[wr_grant_q] = m_axil_awready & ~aw_done_q;
        m_axil_wvalid              = s_axil_wvalid[wr_grant_q] & ~w_done_q;
        s_axil_wready[wr_grant_q]  = m_axil_wready & ~w_done_q;
        aw_all = aw_done_q | (m_axil_awvalid & m_axil_awready);
        w_all  = w_done_q | (m_axil_wvalid & m_axil_wready);
        if (aw_all && w_all) begin
          wr_state_d = WR_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end else begin
          aw_done_d = aw_all;
          w_done_d  = w_all;
        end
      end
      WR_RESP: begin
        s_axil_bvalid[wr_grant_q] = m_axil_bvalid;
        bresp_a[wr_grant_q]       = m_axil_bresp;
        m_axil_bready             = s_axil_bready[wr_grant_q];
        if (m_axil_bvalid && s_axil_bready[wr_grant_q]) begin
          wr_state_d = WR_IDLE;
          wr_ptr_d   = next_idx(wr_grant_q);
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read path: independent of the write path.
  always_comb begin
    rd_state_d     = rd_state_q;
    rd_grant_d     = rd_grant_q;
    rd_ptr_d       = rd_ptr_q;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      rdata_a[i] = '0;
      rresp_a[i] = AXIL_RESP_OKAY;
    end
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_arb_valid) begin
          rd_grant_d = rd_arb_grant;
          rd_state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        m_axil_arvalid             = s_axil_arvalid[rd_grant_q];
        s_axil_arready[rd_grant_q] = m_axil_arready;
        if (m_axil_arvalid && m_axil_arready) rd_state_d = RD_RESP;
      end
      RD_RESP: begin
        s_axil_rvalid[rd_grant_q] = m_axil_rvalid;
        rdata_a[rd_grant_q]       = m_axil_rdata;
        rresp_a[rd_grant_q]       = m_axil_rresp;
        m_axil_rready             = s_axil_rready[rd_grant_q];
        if (m_axil_rvalid && s_axil_rready[rd_grant_q]) begin
          rd_state_d = RD_IDLE;
          rd_ptr_d   = next_idx(rd_grant_q);
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

endmodule
